decode_stage: RTL and testbench
===============================

# decode_stage

Decode and issue stage placed directly upstream of the ALU stage. It accepts one 32-bit RV32I instruction per cycle over a valid/ready handshake and decodes the supported subset, ADDI and ADD. It drives register-file read addresses, the immediate, `input_a_is_immediate`, `alu_op` and the destination register into the ALU stage. A register scoreboard stalls issue on read-after-write hazards until writeback clears the destination.

## Interface
Parameters:
- `XLEN`, 32: instruction width. Only 32 is supported.

Ports:
- `clk`  in  1  clock. All state updates on its rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `instr_valid`  in  1  fetch presents an instruction.
- `instr`  in  32  instruction word.
- `instr_ready`  out  1  decode accepts `instr` this cycle.
- `wb_valid`  in  1  writeback retires a result.
- `wb_rd`  in  5  register being written back. Its busy bit is cleared.
- `regfile_rd0_addr`  out  5  rs2 read address. The register file reads combinationally.
- `regfile_rd1_addr`  out  5  rs1 read address.
- `immediate`  out  12  I-type immediate, `instr[31:20]`.
- `input_a_is_immediate`  out  1  1 for ADDI, 0 otherwise.
- `alu_op`  out  `alu_command_t`  `ALU_ADD` or `ALU_NONE`.
- `dest_rd`  out  5  destination register travelling with `alu_op`.
- `illegal_instr`  out  1  sticky; set on an unsupported encoding.

## Operation
- FSM states: RUN, HALT. Reset enters RUN. RUN moves to HALT when an illegal instruction is accepted. HALT holds until reset.
- Decode:
  - ADDI: opcode 0010011, funct3 000. Produces `ALU_ADD`, `input_a_is_immediate=1`, `immediate=instr[31:20]`, `regfile_rd1_addr=rs1`, `regfile_rd0_addr=0`.
  - ADD: opcode 0110011, funct3 000, funct7 0000000. Produces `ALU_ADD`, `input_a_is_immediate=0`, `immediate=0`, `regfile_rd1_addr=rs1`, `regfile_rd0_addr=rs2`.
  - Any other encoding is illegal.
- Scoreboard: a 32-bit busy vector.
  - Issuing an ADD/ADDI with rd≠0 sets `busy[rd]`.
  - `wb_valid` clears `busy[wb_rd]`.
  - Bit 0 always reads 0.
  - If issue-set and wb-clear hit the same register in the same cycle, the set wins.
- Hazard: a source is busy when its busy bit is 1 and the same-cycle writeback does not clear it.
  - ADDI checks rs1 only. ADD checks rs1 and rs2.
  - A hazard on a source in the same cycle as a clear of that source does not stall; the write lands at that edge.
- `instr_ready` = (state==RUN) and no hazard on the presented `instr`. It is combinational from `instr`, the busy vector and `wb_*`, and is independent of `instr_valid`.
- Issue happens when `instr_valid && instr_ready`. Legal instructions update all outputs at the next edge.
- An illegal instruction issues a bubble, sets `illegal_instr` and enters HALT.
- Cycles with no issue drive a bubble at the next edge: `alu_op=ALU_NONE`, `immediate=0`, `input_a_is_immediate=0`, `dest_rd=0`. Read addresses hold their previous values.

## Timing
- Reset values:
  - `alu_op=ALU_NONE`; `immediate`, `input_a_is_immediate`, `dest_rd` and both read addresses are 0.
  - `illegal_instr=0`; busy vector all 0; state RUN.
- `instr_ready` is 1 in the first cycle after reset.
- Latency: an instruction accepted at edge N appears on the outputs after edge N. The ALU result follows one cycle later.
- Throughput: one instruction per cycle absent hazards.
- A stall holds `instr` at the fetch side, and fetch must keep `instr` stable while `instr_valid` is high. Decode drives bubbles during the stall.
- Reset mid-stall or mid-HALT clears the scoreboard and returns to RUN at the next edge. In-flight writebacks after reset are ignored, since the busy bits are already 0.

## Configuration
- `DECODE_SCOREBOARD_EN`:
  - Defined: scoreboard and hazard stall as above.
  - Undefined: no busy vector; `instr_ready` = (state==RUN); `wb_valid`/`wb_rd` are ignored. Software or upstream logic must guarantee hazard-free streams.

## Test plan
- Reset, then ADDI x5,x0,7 (0x00700293) with `instr_valid=1` for one cycle:
  - Next cycle: `alu_op=ALU_ADD`, `immediate=7`, `input_a_is_immediate=1`, `regfile_rd1_addr=0`, `dest_rd=5`.
  - The following cycle returns to a bubble.
- ADDI x5,x0,7 then ADD x6,x5,x5 (0x00528333) back-to-back, no writeback:
  - `instr_ready=0` while ADD is presented; bubbles are driven.
  - Pulse `wb_valid` with `wb_rd=5`: ADD is accepted that same cycle.
  - Next cycle: `regfile_rd0_addr=5`, `regfile_rd1_addr=5`, `input_a_is_immediate=0`, `dest_rd=6`.
- ADDI x0,x0,1 (0x00100013) followed by ADD x7,x0,x0 (0x000003B3): no stall, since x0 is never busy.
- `instr=0x00000000` accepted:
  - `illegal_instr=1` and stays 1; `alu_op=ALU_NONE`.
  - `instr_ready=0` for every later cycle until `reset_n=0`. After that reset, `illegal_instr=0` and `instr_ready=1`.
- ADDI x5 issued in the same cycle that `wb_valid`/`wb_rd=5` retires an older x5 write:
  - `busy[5]` remains set.
  - A subsequent ADD reading x5 stalls until the next x5 writeback.
- With `DECODE_SCOREBOARD_EN` undefined, repeat the dependent-pair scenario: ADD is accepted the cycle after ADDI with no stall.

Source files
------------

// File: rtl/decode_stage_if.sv
// ALU command encoding and the decode-stage bus: fetch handshake, writeback
// retire port and the issue signals that feed the ALU stage.
package decode_pkg;
    typedef enum logic [1:0] {
        ALU_NONE = 2'd0,
        ALU_ADD  = 2'd1
    } alu_command_t;
endpackage

interface decode_stage_if #(parameter int XLEN = 32);
    import decode_pkg::*;

    logic            instr_valid;
    logic [XLEN-1:0] instr;
    logic            instr_ready;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [4:0]      regfile_rd0_addr;
    logic [4:0]      regfile_rd1_addr;
    logic [11:0]     immediate;
    logic            input_a_is_immediate;
    alu_command_t    alu_op;
    logic [4:0]      dest_rd;
    logic            illegal_instr;

    modport slave (
        input  instr_valid, instr, wb_valid, wb_rd,
        output instr_ready, regfile_rd0_addr, regfile_rd1_addr, immediate,
               input_a_is_immediate, alu_op, dest_rd, illegal_instr
    );

    modport master (
        output instr_valid, instr, wb_valid, wb_rd,
        input  instr_ready, regfile_rd0_addr, regfile_rd1_addr, immediate,
               input_a_is_immediate, alu_op, dest_rd, illegal_instr
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode/issue for ADDI and ADD with a sticky illegal-instruction halt.
// Define DECODE_SCOREBOARD_EN to add the busy-vector RAW hazard stall.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    decode_stage_if.slave bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] ir;
    logic [4:0]      rd, rs1, rs2;
    logic            is_addi, is_add, legal;
    logic            hazard, ready, issue;

    alu_command_t    alu_op_q, alu_op_d;
    logic [11:0]     imm_q, imm_d;
    logic            a_imm_q, a_imm_d;
    logic [4:0]      dest_q, dest_d;
    logic [4:0]      rd0_q, rd0_d;
    logic [4:0]      rd1_q, rd1_d;
    logic            illegal_q, illegal_d;

    assign ir      = bus.instr;
    assign rd      = ir[11:7];
    assign rs1     = ir[19:15];
    assign rs2     = ir[24:20];
    assign is_addi = (ir[6:0] == 7'b0010011) && (ir[14:12] == 3'b000);
    assign is_add  = (ir[6:0] == 7'b0110011) && (ir[14:12] == 3'b000)
                     && (ir[31:25] == 7'b0000000);
    assign legal   = is_addi || is_add;

`ifdef DECODE_SCOREBOARD_EN
    logic [31:0] busy_q, busy_d;
    logic [31:0] wb_clr;
    logic [31:0] busy_eff;

    // A source retiring this cycle is treated as ready: the write lands at this edge.
    assign wb_clr   = bus.wb_valid ? (32'd1 << bus.wb_rd) : 32'd0;
    assign busy_eff = busy_q & ~wb_clr;
    assign hazard   = ((is_addi || is_add) && busy_eff[rs1])
                      || (is_add && busy_eff[rs2]);

    always_comb begin
        busy_d = busy_q & ~wb_clr;
        if (issue && legal && rd != 5'd0)
            busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) busy_q <= '0;
        else          busy_q <= busy_d;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wb_valid, bus.wb_rd};
    assign hazard    = 1'b0;
`endif

    assign issue = bus.instr_valid && ready;

    always_comb begin
        ready     = 1'b0;
        state_d   = state_q;
        illegal_d = illegal_q;
        alu_op_d  = ALU_NONE;
        imm_d     = '0;
        a_imm_d   = 1'b0;
        dest_d    = '0;
        rd0_d     = rd0_q;
        rd1_d     = rd1_q;
        case (state_q)
            RUN: begin
                ready = !hazard;
                if (issue) begin
                    if (legal) begin
                        alu_op_d = ALU_ADD;
                        imm_d    = is_addi ? ir[31:20] : 12'd0;
                        a_imm_d  = is_addi;
                        dest_d   = rd;
                        rd1_d    = rs1;
                        rd0_d    = is_add ? rs2 : 5'd0;
                    end else begin
                        state_d   = HALT;
                        illegal_d = 1'b1;
                    end
                end
            end
            HALT: ready = 1'b0;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= RUN;
            illegal_q <= 1'b0;
            alu_op_q  <= ALU_NONE;
            imm_q     <= '0;
            a_imm_q   <= 1'b0;
            dest_q    <= '0;
            rd0_q     <= '0;
            rd1_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            alu_op_q  <= alu_op_d;
            imm_q     <= imm_d;
            a_imm_q   <= a_imm_d;
            dest_q    <= dest_d;
            rd0_q     <= rd0_d;
            rd1_q     <= rd1_d;
        end
    end

    assign bus.instr_ready          = ready;
    assign bus.alu_op               = alu_op_q;
    assign bus.immediate            = imm_q;
    assign bus.input_a_is_immediate = a_imm_q;
    assign bus.dest_rd              = dest_q;
    assign bus.regfile_rd0_addr     = rd0_q;
    assign bus.regfile_rd1_addr     = rd1_q;
    assign bus.illegal_instr        = illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected issues are queued by the stimulus
// and popped by a monitor whenever the ALU-side outputs carry an operation.
module tb_decode_stage;
    import decode_pkg::*;

    typedef struct packed {
        alu_command_t op;
        logic [11:0]  imm;
        logic         aimm;
        logic [4:0]   rd0;
        logic [4:0]   rd1;
        logic [4:0]   dest;
    } exp_t;

    localparam logic [31:0] ADDI_X5_7  = 32'h0070_0293;
    localparam logic [31:0] ADD_X6_X5  = 32'h0052_8333;
    localparam logic [31:0] ADDI_X0_1  = 32'h0010_0013;
    localparam logic [31:0] ADD_X7_X0  = 32'h0000_03B3;

    localparam exp_t E_ADDI5 = '{op: ALU_ADD, imm: 12'd7, aimm: 1'b1, rd0: 5'd0, rd1: 5'd0, dest: 5'd5};
    localparam exp_t E_ADD6  = '{op: ALU_ADD, imm: 12'd0, aimm: 1'b0, rd0: 5'd5, rd1: 5'd5, dest: 5'd6};
    localparam exp_t E_ADDI0 = '{op: ALU_ADD, imm: 12'd1, aimm: 1'b1, rd0: 5'd0, rd1: 5'd0, dest: 5'd0};
    localparam exp_t E_ADD7  = '{op: ALU_ADD, imm: 12'd0, aimm: 1'b0, rd0: 5'd0, rd1: 5'd0, dest: 5'd7};

    logic clk = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    decode_stage_if bus();

    decode_stage dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every non-bubble output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.alu_op != ALU_NONE) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_issue: got op %0d dest %0d expected no issue", bus.alu_op, bus.dest_rd);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("alu_op", 32'(bus.alu_op), 32'(e.op));
                chk("immediate", 32'(bus.immediate), 32'(e.imm));
                chk("a_is_imm", 32'(bus.input_a_is_immediate), 32'(e.aimm));
                chk("rd0_addr", 32'(bus.regfile_rd0_addr), 32'(e.rd0));
                chk("rd1_addr", 32'(bus.regfile_rd1_addr), 32'(e.rd1));
                chk("dest_rd", 32'(bus.dest_rd), 32'(e.dest));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present w until accepted; called and returns at 1 time unit past a rising edge.
    task automatic send(input logic [31:0] w, input exp_t e);
        int n;
        n = 0;
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        sb.push_back(e);
        @(negedge clk);
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: instr 0x%0h ready %0b expected 1", w, bus.instr_ready);
        end
        step();
        bus.instr_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] r);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = r;
        step();
        bus.wb_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        reset_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        @(negedge clk);
        chk("rst_alu_op", 32'(bus.alu_op), 32'(ALU_NONE));
        chk("rst_imm", 32'(bus.immediate), 0);
        chk("rst_a_imm", 32'(bus.input_a_is_immediate), 0);
        chk("rst_dest", 32'(bus.dest_rd), 0);
        chk("rst_rd0", 32'(bus.regfile_rd0_addr), 0);
        chk("rst_rd1", 32'(bus.regfile_rd1_addr), 0);
        chk("rst_illegal", 32'(bus.illegal_instr), 0);
        chk("rst_ready", 32'(bus.instr_ready), 1);
        step();

        // Single ADDI, then a bubble.
        send(ADDI_X5_7, E_ADDI5);
        @(negedge clk);
        @(negedge clk);
        chk("bubble_op", 32'(bus.alu_op), 32'(ALU_NONE));
        chk("bubble_imm", 32'(bus.immediate), 0);
        chk("bubble_a_imm", 32'(bus.input_a_is_immediate), 0);
        chk("bubble_dest", 32'(bus.dest_rd), 0);
        step();
        wb(5'd5);

        // Dependent pair ADDI x5 -> ADD x6,x5,x5.
        bus.instr_valid = 1'b1;
        bus.instr       = ADDI_X5_7;
        sb.push_back(E_ADDI5);
        @(negedge clk);
        chk("pair_addi_ready", 32'(bus.instr_ready), 1);
        step();
        bus.instr = ADD_X6_X5;
`ifdef DECODE_SCOREBOARD_EN
        @(negedge clk);
        chk("raw_stall_ready", 32'(bus.instr_ready), 0);
        step();
        @(negedge clk);
        chk("raw_stall_ready2", 32'(bus.instr_ready), 0);
        chk("raw_stall_bubble", 32'(bus.alu_op), 32'(ALU_NONE));
        step();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd5;
        sb.push_back(E_ADD6);
        @(negedge clk);
        chk("wb_release_ready", 32'(bus.instr_ready), 1);
        step();
        bus.wb_valid = 1'b0;
`else
        sb.push_back(E_ADD6);
        @(negedge clk);
        chk("nosb_pair_ready", 32'(bus.instr_ready), 1);
        step();
`endif
        bus.instr_valid = 1'b0;
        @(negedge clk);
        step();
        wb(5'd6);

        // x0 destination never creates a hazard.
        bus.instr_valid = 1'b1;
        bus.instr       = ADDI_X0_1;
        sb.push_back(E_ADDI0);
        @(negedge clk);
        chk("x0_addi_ready", 32'(bus.instr_ready), 1);
        step();
        bus.instr = ADD_X7_X0;
        sb.push_back(E_ADD7);
        @(negedge clk);
        chk("x0_add_ready", 32'(bus.instr_ready), 1);
        step();
        bus.instr_valid = 1'b0;
        @(negedge clk);
        step();
        wb(5'd7);

`ifdef DECODE_SCOREBOARD_EN
        // Issue-set of x5 beats a same-cycle writeback clear of x5.
        send(ADDI_X5_7, E_ADDI5);
        bus.wb_valid    = 1'b1;
        bus.wb_rd       = 5'd5;
        bus.instr_valid = 1'b1;
        bus.instr       = ADDI_X5_7;
        sb.push_back(E_ADDI5);
        @(negedge clk);
        chk("setwin_addi_ready", 32'(bus.instr_ready), 1);
        step();
        bus.wb_valid = 1'b0;
        bus.instr    = ADD_X6_X5;
        @(negedge clk);
        chk("setwin_stall", 32'(bus.instr_ready), 0);
        step();
        @(negedge clk);
        chk("setwin_stall2", 32'(bus.instr_ready), 0);
        step();
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd5;
        sb.push_back(E_ADD6);
        @(negedge clk);
        chk("setwin_release", 32'(bus.instr_ready), 1);
        step();
        bus.wb_valid    = 1'b0;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        step();
        wb(5'd6);
`endif

        // Leave x5 busy, then halt on an illegal word and recover through reset.
        send(ADDI_X5_7, E_ADDI5);
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h0000_0000;
        @(negedge clk);
        chk("illegal_accept_ready", 32'(bus.instr_ready), 1);
        step();
        bus.instr = ADDI_X0_1;
        @(negedge clk);
        chk("illegal_set", 32'(bus.illegal_instr), 1);
        chk("illegal_bubble", 32'(bus.alu_op), 32'(ALU_NONE));
        for (int i = 0; i < 3; i++) begin
            chk("halt_ready", 32'(bus.instr_ready), 0);
            chk("halt_sticky", 32'(bus.illegal_instr), 1);
            step();
            @(negedge clk);
        end
        step();
        bus.instr_valid = 1'b0;
        reset_n         = 1'b0;
        step();
        reset_n   = 1'b1;
        bus.instr = ADD_X6_X5;
        @(negedge clk);
        chk("post_rst_illegal", 32'(bus.illegal_instr), 0);
        chk("post_rst_ready", 32'(bus.instr_ready), 1);
        chk("post_rst_op", 32'(bus.alu_op), 32'(ALU_NONE));
        step();

        chk("queue_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
